mem_access_unit: RTL

Memory-stage load/store initiator for the pipelined CPU. It takes a load or store from the EX/MEM boundary and issues a word-aligned, byte-enabled request to a variable-latency data memory over a req/ack handshake. For loads it extracts, sign-extends or zero-extends and returns the result toward write-back. It stalls the pipeline while a transaction is outstanding.

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store initiator: big-endian byte lanes, req/ack handshake, load extension.
// Define MAU_TIMEOUT_EN to add an ack watchdog that aborts with a bus_err pulse after TIMEOUT cycles.
module mem_access_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign,
    mem_access_unit_if.master mem,
    output logic              bus_err
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              op_load;
    logic              op_unsigned;
    logic [1:0]        op_size;
    logic [1:0]        op_off;
    logic [4:0]        op_rd;

    logic              misaligned_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_c;

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

    assign stall = (state == ACCESS) && !mem.mem_ack;

    // Alignment, lane enables and replicated store data for the op at the EX/MEM boundary
    always_comb begin
        misaligned_c = 1'b0;
        be_c         = 4'b1111;
        wdata_c      = ex_wdata;
        case (ex_size)
            2'b00: begin
                be_c    = 4'b1000 >> ex_addr[1:0];
                wdata_c = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                misaligned_c = ex_addr[0];
                be_c         = ex_addr[1] ? 4'b0011 : 4'b1100;
                wdata_c      = {2{ex_wdata[15:0]}};
            end
            default: misaligned_c = (ex_addr[1:0] != 2'b00);
        endcase
    end

    // Big-endian lane select and extension of returned read data
    always_comb begin
        lane_h = op_off[1] ? mem.mem_rdata[15:0] : mem.mem_rdata[31:16];
        case (op_off)
            2'd0:    lane_b = mem.mem_rdata[31:24];
            2'd1:    lane_b = mem.mem_rdata[23:16];
            2'd2:    lane_b = mem.mem_rdata[15:8];
            default: lane_b = mem.mem_rdata[7:0];
        endcase
        case (op_size)
            2'b00:   load_c = op_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_c = op_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_c = mem.mem_rdata;
        endcase
    end

`ifdef MAU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             bus_err_q;
    assign bus_err = bus_err_q;
`else
    // Without the watchdog TIMEOUT has no effect; it is folded into a constant zero
    assign bus_err = 1'b0 && (TIMEOUT != 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= 4'b0;
            wdata_q     <= 32'h0;
            op_load     <= 1'b0;
            op_unsigned <= 1'b0;
            op_size     <= 2'b0;
            op_off      <= 2'b0;
            op_rd       <= 5'h0;
            wb_valid    <= 1'b0;
            wb_rd       <= 5'h0;
            wb_data     <= 32'h0;
            misalign    <= 1'b0;
`ifdef MAU_TIMEOUT_EN
            wait_cnt    <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
`ifdef MAU_TIMEOUT_EN
            bus_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (ex_valid && (ex_load || ex_store)) begin
                        if (misaligned_c) begin
                            misalign <= 1'b1;
                        end else begin
                            state       <= ACCESS;
                            req_q       <= 1'b1;
                            we_q        <= ex_store;
                            addr_q      <= {ex_addr[ADDR_W-1:2], 2'b00};
                            be_q        <= be_c;
                            wdata_q     <= wdata_c;
                            // A simultaneous load+store is executed as a store
                            op_load     <= !ex_store;
                            op_unsigned <= ex_unsigned;
                            op_size     <= ex_size;
                            op_off      <= ex_addr[1:0];
                            op_rd       <= ex_rd;
`ifdef MAU_TIMEOUT_EN
                            wait_cnt    <= '0;
`endif
                        end
                    end
                end
                default: begin
                    if (mem.mem_ack) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                        if (op_load) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= op_rd;
                            wb_data  <= load_c;
                        end
                    end
`ifdef MAU_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= IDLE;
                        req_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
            endcase
        end
    end
endmodule
